// File: rtl/debounce_botoes.sv
// Multi-channel push-button conditioner: synchroniser, symmetric debounce and
// press / release / long-press event generation, one independent pipeline per channel.
module debounce_botoes #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned DB_CYCLES   = 5000,
    parameter int unsigned LONG_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] botao,
    output logic [N_CH-1:0] estavel,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,  // 'release' is a reserved word
    output logic [N_CH-1:0] longo,
    output logic [N_CH-1:0] longo_ativo
);

    localparam int unsigned DB_W   = $clog2(DB_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    typedef enum logic [1:0] {
        SOLTO       = 2'd0,
        CONF_PRESS  = 2'd1,
        PRESSIONADO = 2'd2,
        CONF_SOLTA  = 2'd3
    } estado_t;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        estado_t                state_q, state_d;
        logic [DB_W-1:0]        db_q, db_d;
        logic [HOLD_W-1:0]      hold_q, hold_d;
        logic                   est_q, est_d;
        logic                   press_q, press_d;
        logic                   rel_q, rel_d;
        logic                   longo_q, longo_d;
        logic                   la_q, la_d;

        // Metastability synchroniser for the asynchronous button level.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], botao[i]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= SOLTO;
                db_q    <= '0;
                hold_q  <= '0;
                est_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                longo_q <= 1'b0;
                la_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                db_q    <= db_d;
                hold_q  <= hold_d;
                est_q   <= est_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                longo_q <= longo_d;
                la_q    <= la_d;
            end
        end

        always_comb begin
            state_d = state_q;
            db_d    = db_q;
            hold_d  = hold_q;
            est_d   = est_q;
            la_d    = la_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            longo_d = 1'b0;

            // Hold time runs while the button is accepted as pressed, saturating at the threshold.
            if ((state_q == PRESSIONADO || state_q == CONF_SOLTA) &&
                (hold_q != HOLD_W'(LONG_CYCLES))) begin
                hold_d = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_W'(LONG_CYCLES - 1)) begin
                    longo_d = 1'b1;
                    la_d    = 1'b1;
                end
            end

            case (state_q)
                SOLTO: begin
                    if (s) begin
                        state_d = CONF_PRESS;
                        db_d    = DB_W'(1);
                    end else begin
                        db_d = '0;
                    end
                end
                CONF_PRESS: begin
                    if (!s) begin
                        state_d = SOLTO;
                        db_d    = '0;
                    end else if (db_q == DB_W'(DB_CYCLES - 1)) begin
                        state_d = PRESSIONADO;
                        est_d   = 1'b1;
                        press_d = 1'b1;
                        hold_d  = '0;
                    end else begin
                        db_d = db_q + DB_W'(1);
                    end
                end
                PRESSIONADO: begin
                    if (!s) begin
                        state_d = CONF_SOLTA;
                        db_d    = DB_W'(1);
                    end
                end
                CONF_SOLTA: begin
                    if (s) begin
                        state_d = PRESSIONADO;
                        db_d    = '0;
                    end else if (db_q == DB_W'(DB_CYCLES - 1)) begin
                        // Accepted release wins over any long-press reached on the same edge.
                        state_d = SOLTO;
                        est_d   = 1'b0;
                        rel_d   = 1'b1;
                        la_d    = 1'b0;
                        longo_d = 1'b0;
                        hold_d  = '0;
                    end else begin
                        db_d = db_q + DB_W'(1);
                    end
                end
                default: begin
                    state_d = SOLTO;
                    db_d    = '0;
                end
            endcase
        end

        assign estavel[i]       = est_q;
        assign press[i]         = press_q;
        assign release_pulse[i] = rel_q;
        assign longo[i]         = longo_q;
        assign longo_ativo[i]   = la_q;
    end

endmodule

// File: tb/tb_debounce_botoes.sv
// Bench for debounce_botoes: directed scenarios plus randomized button activity,
// every cycle compared against a run-length reference model.
module tb_debounce_botoes;

    localparam int N_CH = 2;
    localparam int DB   = 4;
    localparam int LONG = 10;
    localparam int SYNC = 2;
    localparam logic [N_CH-1:0] ZERO = '0;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] botao = '0;
    logic [N_CH-1:0] estavel, press, release_pulse, longo, longo_ativo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    debounce_botoes #(
        .N_CH(N_CH), .DB_CYCLES(DB), .LONG_CYCLES(LONG), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .botao(botao),
        .estavel(estavel), .press(press), .release_pulse(release_pulse),
        .longo(longo), .longo_ativo(longo_ativo)
    );

    // Reference model: raw-sample history for the synchroniser delay, a run length of
    // samples disagreeing with the accepted level, and a saturating hold time.
    logic [N_CH-1:0] raw_hist [$];
    int              run  [N_CH];
    int              hold [N_CH];
    logic [N_CH-1:0] m_est, m_press, m_rel, m_longo, m_la;
    logic [N_CH-1:0] seen_press, seen_rel, seen_longo;

    task automatic model_reset();
        raw_hist.delete();
        for (int c = 0; c < N_CH; c++) begin
            run[c]  = 0;
            hold[c] = 0;
        end
        m_est = '0; m_press = '0; m_rel = '0; m_longo = '0; m_la = '0;
    endtask

    task automatic model_edge(input logic [N_CH-1:0] b);
        logic [N_CH-1:0] s;
        s = '0;
        if (raw_hist.size() >= SYNC) s = raw_hist[raw_hist.size() - SYNC];
        raw_hist.push_back(b);
        if (raw_hist.size() > SYNC) raw_hist.delete(0);
        for (int c = 0; c < N_CH; c++) begin
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            m_longo[c] = 1'b0;
            if (s[c] != m_est[c]) run[c]++;
            else run[c] = 0;
            if (run[c] == DB) begin
                run[c]   = 0;
                hold[c]  = 0;
                m_est[c] = ~m_est[c];
                if (m_est[c]) m_press[c] = 1'b1;
                else begin
                    m_rel[c] = 1'b1;
                    m_la[c]  = 1'b0;
                end
            end else if (m_est[c] && hold[c] < LONG) begin
                hold[c]++;
                if (hold[c] == LONG) begin
                    m_longo[c] = 1'b1;
                    m_la[c]    = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [N_CH-1:0] obs, input logic [N_CH-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @%0t observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("estavel", estavel, m_est);
        chk("press", press, m_press);
        chk("release", release_pulse, m_rel);
        chk("longo", longo, m_longo);
        chk("longo_ativo", longo_ativo, m_la);
    endtask

    task automatic clear_seen();
        seen_press = '0; seen_rel = '0; seen_longo = '0;
    endtask

    // One clock edge: model sees the level the DUT samples, outputs compared 1 time unit later.
    task automatic tick();
        logic [N_CH-1:0] b;
        b = botao;
        @(posedge clk);
        model_edge(b);
        #1;
        chk_model();
        seen_press |= press;
        seen_rel   |= release_pulse;
        seen_longo |= longo;
    endtask

    task automatic run_ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_reset(input int cycles);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_estavel", estavel, ZERO);
        chk("rst_press", press, ZERO);
        chk("rst_release", release_pulse, ZERO);
        chk("rst_longo", longo, ZERO);
        chk("rst_longo_ativo", longo_ativo, ZERO);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_estavel", estavel, ZERO);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        clear_seen();

        // Power-on reset
        #1;
        chk("por_estavel", estavel, ZERO);
        chk("por_longo_ativo", longo_ativo, ZERO);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_ticks(3);

        // Clean press, long press and release on channel 0
        botao = 2'b01;
        run_ticks(5);
        chk("clean_pre_estavel", estavel, 2'b00);
        tick();
        chk("clean_press", press, 2'b01);
        chk("clean_estavel", estavel, 2'b01);
        run_ticks(9);
        chk("clean_no_la_yet", longo_ativo, 2'b00);
        tick();
        chk("clean_longo", longo, 2'b01);
        chk("clean_la", longo_ativo, 2'b01);
        run_ticks(5);
        chk("clean_la_held", longo_ativo, 2'b01);
        botao = 2'b00;
        run_ticks(5);
        chk("rel_pre_estavel", estavel, 2'b01);
        tick();
        chk("rel_pulse", release_pulse, 2'b01);
        chk("rel_estavel", estavel, 2'b00);
        chk("rel_la_clear", longo_ativo, 2'b00);
        run_ticks(3);

        // Bounce rejection: 3 high, 1 low, 3 high, low
        clear_seen();
        botao = 2'b01; run_ticks(3);
        botao = 2'b00; run_ticks(1);
        botao = 2'b01; run_ticks(3);
        botao = 2'b00; run_ticks(8);
        chk("bounce_no_press", seen_press, 2'b00);
        chk("bounce_estavel", estavel, 2'b00);

        // Release with a 2-cycle high glitch during confirmation
        botao = 2'b01;
        run_ticks(7);
        chk("glitch_pressed", estavel, 2'b01);
        clear_seen();
        botao = 2'b00; run_ticks(2);
        botao = 2'b01; run_ticks(2);
        botao = 2'b00; run_ticks(4);
        chk("glitch_no_release", seen_rel, 2'b00);
        chk("glitch_still_held", estavel, 2'b01);
        run_ticks(3);
        chk("glitch_release_late", seen_rel, 2'b01);
        chk("glitch_estavel", estavel, 2'b00);
        run_ticks(3);

        // Short press: no long-press event
        clear_seen();
        botao = 2'b01; run_ticks(8);
        botao = 2'b00; run_ticks(8);
        chk("short_press", seen_press, 2'b01);
        chk("short_release", seen_rel, 2'b01);
        chk("short_no_longo", seen_longo, 2'b00);

        // Simultaneous press and long press on both channels
        botao = 2'b11;
        run_ticks(5);
        tick();
        chk("simul_press", press, 2'b11);
        run_ticks(9);
        tick();
        chk("simul_longo", longo, 2'b11);
        botao = 2'b00;
        run_ticks(8);
        chk("simul_released", estavel, 2'b00);

        // Reset while channel 0 is held
        botao = 2'b01;
        run_ticks(8);
        chk("midrst_pressed", estavel, 2'b01);
        pulse_reset(3);
        clear_seen();
        run_ticks(5);
        chk("midrst_pre_estavel", estavel, 2'b00);
        tick();
        chk("midrst_repress", press, 2'b01);
        chk("midrst_no_release", seen_rel, 2'b00);
        botao = 2'b00;
        run_ticks(8);

        // Randomized activity at several toggle rates, with occasional resets
        for (int phase = 0; phase < 4; phase++) begin
            int rate;
            case (phase)
                0: rate = 3;
                1: rate = 12;
                2: rate = 40;
                default: rate = 8;
            endcase
            for (int k = 0; k < 400; k++) begin
                logic [N_CH-1:0] b;
                b = botao;
                for (int c = 0; c < N_CH; c++)
                    if ($urandom_range(rate - 1, 0) == 0) b[c] = ~b[c];
                botao = b;
                if ($urandom_range(299, 0) == 0) pulse_reset(2);
                else tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
